// File: rtl/ad_sample_rx.sv
// Serial ADC receiver: CONVST pulse, BUSY wait, MSB-first readout, 1-cycle valid.
// Optional AD_AVG4_EN: output the mean of every 4 conversions.
module ad_sample_rx #(
  parameter int DATA_W   = 16,
  parameter int SCLK_DIV = 4,
  parameter int CONV_W   = 3,
  parameter int BUSY_TO  = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ad_start,
  input  logic              err_clr,
  input  logic              adc_busy,
  input  logic              adc_sdo,
  output logic              adc_convst_n,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  output logic              overrun,
  output logic              timeout_err,
  output logic [31:0]       sample_cnt
);

  localparam int CNT_MAX = (BUSY_TO > CONV_W) ? BUSY_TO : CONV_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = $clog2(SCLK_DIV);
  localparam int HALF_W  = $clog2(2 * DATA_W + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_WAIT,
    S_READ,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_start_d;
  logic              r_busy_m;
  logic              r_busy_s;
  logic [CNT_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  r_div;
  logic [HALF_W-1:0] r_half;
  logic              r_sclk;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_overrun;
  logic              r_timeout;
  logic [31:0]       r_sample_cnt;

  logic w_start_rise;
  logic w_conv_end;
  logic w_busy_done;
  logic w_timeout;
  logic w_half_end;
  logic w_last_half;
  logic w_read_end;

  assign w_start_rise = ad_start & ~r_start_d;
  assign w_conv_end   = (r_state == S_CONV) &&
                        (r_cnt == CNT_W'(CONV_W - 1));
  // First two WAIT cycles still see pre-convst BUSY through the synchroniser
  assign w_busy_done  = (r_state == S_WAIT) &&
                        (r_cnt >= CNT_W'(2)) && !r_busy_s;
  assign w_timeout    = (r_state == S_WAIT) && !w_busy_done &&
                        (r_cnt == CNT_W'(BUSY_TO - 1));
  assign w_half_end   = (r_div == DIV_W'(SCLK_DIV - 1));
  assign w_last_half  = (r_half == HALF_W'(2 * DATA_W));
  assign w_read_end   = (r_state == S_READ) && w_half_end && w_last_half;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start_rise && en) w_next = S_CONV;
      S_CONV:  if (w_conv_end) w_next = S_WAIT;
      S_WAIT: begin
        if (w_busy_done)    w_next = S_READ;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_READ:  if (w_read_end) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_d <= 1'b0;
      r_busy_m  <= 1'b0;
      r_busy_s  <= 1'b0;
      r_cnt     <= '0;
      r_div     <= '0;
      r_half    <= '0;
      r_sclk    <= 1'b0;
      r_shreg   <= '0;
    end else begin
      r_start_d <= ad_start;
      r_busy_m  <= adc_busy;
      r_busy_s  <= r_busy_m;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state == S_CONV || r_state == S_WAIT)
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
      if (r_state == S_READ) begin
        r_div <= w_half_end ? '0 : r_div + 1'b1;
        if (w_half_end && !w_last_half) begin
          r_half <= r_half + 1'b1;
          r_sclk <= ~r_sclk;
          if (!r_sclk)
            r_shreg <= {r_shreg[DATA_W-2:0], adc_sdo};
        end
      end else begin
        r_div  <= '0;
        r_half <= '0;
        r_sclk <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_start_rise && r_state != S_IDLE) r_overrun <= 1'b1;
      else if (err_clr)                      r_overrun <= 1'b0;
      if (w_timeout)    r_timeout <= 1'b1;
      else if (err_clr) r_timeout <= 1'b0;
    end
  end

`ifdef AD_AVG4_EN
  logic [DATA_W+1:0] r_sum;
  logic [1:0]        r_phase;
  logic [DATA_W+1:0] w_sum_nx;

  assign w_sum_nx = r_sum + {2'b00, r_shreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum        <= '0;
      r_phase      <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      r_valid <= 1'b0;
      if (err_clr) begin
        r_sum   <= '0;
        r_phase <= '0;
      end
      // Results land on the last READ cycle so they are visible during DONE
      if (w_read_end) begin
        r_sample_cnt <= r_sample_cnt + 32'd1;
        if (r_phase == 2'd3) begin
          r_data  <= w_sum_nx[DATA_W+1:2];
          r_valid <= 1'b1;
          r_sum   <= '0;
          r_phase <= '0;
        end else begin
          r_sum   <= w_sum_nx;
          r_phase <= r_phase + 2'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      r_valid <= 1'b0;
      // Results land on the last READ cycle so they are visible during DONE
      if (w_read_end) begin
        r_data       <= r_shreg;
        r_valid      <= 1'b1;
        r_sample_cnt <= r_sample_cnt + 32'd1;
      end
    end
  end
`endif

  assign adc_convst_n = (r_state != S_CONV);
  assign adc_cs_n     = (r_state != S_READ);
  assign adc_sclk     = r_sclk;
  assign sample_data  = r_data;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;
  assign timeout_err  = r_timeout;
  assign sample_cnt   = r_sample_cnt;

endmodule

// File: tb/tb_ad_sample_rx.sv
// Randomised bench for ad_sample_rx with a behavioural ADC and sample model.
// Define AD_AVG4_EN to also exercise the 4-sample averaging build.
module tb_ad_sample_rx;

  localparam int DW = 16;
  localparam int SD = 4;
  localparam int CW = 3;
  localparam int BT = 1000;
  localparam int READ_CYC = SD * (2 * DW + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          ad_start = 1'b0;
  logic          err_clr = 1'b0;
  logic          adc_busy = 1'b0;
  logic          adc_sdo;
  logic          adc_convst_n;
  logic          adc_cs_n;
  logic          adc_sclk;
  logic [DW-1:0] sample_data;
  logic          sample_valid;
  logic          overrun;
  logic          timeout_err;
  logic [31:0]   sample_cnt;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] adc_word = '0;
  int rise_idx = 0;
  int sclk_total = 0;
  int busy_dly = 10;
  bit busy_stuck = 1'b0;

  int n_conv, n_cs, n_valid, rises, t_to;
  logic [DW-1:0] d_valid;

  // reference model state
  int unsigned m_cnt = 0;
  int m_acc[$];
  bit e_v;
  logic [DW-1:0] e_d;

  ad_sample_rx #(
    .DATA_W(DW), .SCLK_DIV(SD), .CONV_W(CW), .BUSY_TO(BT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ad_start(ad_start),
    .err_clr(err_clr), .adc_busy(adc_busy), .adc_sdo(adc_sdo),
    .adc_convst_n(adc_convst_n), .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk), .sample_data(sample_data),
    .sample_valid(sample_valid), .overrun(overrun),
    .timeout_err(timeout_err), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  // ADC: MSB presented at CS fall, next bit after each SCLK rise
  always @(posedge adc_sclk or posedge adc_cs_n)
    if (adc_cs_n) rise_idx <= 0;
    else          rise_idx <= rise_idx + 1;

  assign adc_sdo = (rise_idx < DW) ? adc_word[DW-1-rise_idx] : 1'b0;

  always @(posedge adc_sclk) sclk_total <= sclk_total + 1;

  initial forever begin
    @(negedge adc_convst_n);
    adc_busy = 1'b1;
    repeat (busy_dly) @(posedge clk);
    while (busy_stuck) @(posedge clk);
    adc_busy = 1'b0;
  end

  task automatic model_conv(input logic [DW-1:0] w);
    int s;
    m_cnt++;
`ifdef AD_AVG4_EN
    m_acc.push_back(int'(w));
    e_v = 1'b0;
    if (m_acc.size() == 4) begin
      s = 0;
      foreach (m_acc[k]) s += m_acc[k];
      e_v = 1'b1;
      e_d = DW'(s / 4);
      m_acc.delete();
    end
`else
    s = 0;
    e_v = 1'b1;
    e_d = w;
`endif
  endtask

  task automatic conv(input logic [DW-1:0] w, input int ncyc,
                      input int slen, input int s2, input bit clr2);
    int r0;
    @(negedge clk);
    adc_word = w;
    busy_dly = $urandom_range(3, 20);
    r0 = sclk_total;
    n_conv = 0; n_cs = 0; n_valid = 0; t_to = 0; d_valid = '0;
    ad_start = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (!adc_convst_n) n_conv++;
      if (!adc_cs_n) n_cs++;
      if (sample_valid) begin
        n_valid++;
        d_valid = sample_data;
      end
      if (timeout_err && t_to == 0) t_to = i;
      err_clr = 1'b0;
      if (i == slen) ad_start = 1'b0;
      if (s2 != 0 && i == s2) begin
        ad_start = 1'b1;
        err_clr = clr2;
      end
      if (s2 != 0 && i == s2 + 1) ad_start = 1'b0;
    end
    ad_start = 1'b0;
    err_clr = 1'b0;
    rises = sclk_total - r0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    m_acc.delete();
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({adc_convst_n, adc_cs_n, adc_sclk} !== 3'b110) begin
      failures++;
      $display("FAIL reset_pins got=%b exp=110",
               {adc_convst_n, adc_cs_n, adc_sclk});
    end
    checks++;
    if ({sample_valid, overrun, timeout_err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000",
               {sample_valid, overrun, timeout_err});
    end
    checks++;
    if (sample_data !== '0 || sample_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%0d exp=0/0", sample_data, sample_cnt);
    end
    rst_n = 1'b1;
    en = 1'b1;
    m_cnt = 0;
    m_acc.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    conv(16'hA5C3, 200, 1, 0, 1'b0);
    model_conv(16'hA5C3);
    checks++;
    if (rises !== DW) begin
      failures++;
      $display("FAIL basic_rises got=%0d exp=%0d", rises, DW);
    end
    checks++;
    if (n_cs !== READ_CYC) begin
      failures++;
      $display("FAIL basic_cs_len got=%0d exp=%0d", n_cs, READ_CYC);
    end
    checks++;
    if (n_conv !== CW) begin
      failures++;
      $display("FAIL basic_convst_len got=%0d exp=%0d", n_conv, CW);
    end
    checks++;
    if (n_valid !== int'(e_v) || (e_v && d_valid !== e_d)) begin
      failures++;
      $display("FAIL basic_data got=%0d/%h exp=%0d/%h",
               n_valid, d_valid, e_v, e_d);
    end
    checks++;
    if (sample_cnt !== m_cnt) begin
      failures++;
      $display("FAIL basic_cnt got=%0d exp=%0d", sample_cnt, m_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w;
    for (int k = 0; k < 6; k++) begin
      w = DW'($urandom);
      conv(w, 200, 1, 0, 1'b0);
      model_conv(w);
      checks++;
      if (n_valid !== int'(e_v) || (e_v && d_valid !== e_d)) begin
        failures++;
        $display("FAIL b2b_data[%0d] got=%0d/%h exp=%0d/%h",
                 k, n_valid, d_valid, e_v, e_d);
      end
      checks++;
      if (sample_cnt !== m_cnt || rises !== DW) begin
        failures++;
        $display("FAIL b2b_cnt[%0d] got=%0d/%0d exp=%0d/%0d",
                 k, sample_cnt, rises, m_cnt, DW);
      end
    end
  endtask

  task automatic test_overrun();
    logic [DW-1:0] w;
    w = DW'($urandom);
    // held 2 cycles, second edge mid-READ together with err_clr
    conv(w, 200, 2, 70, 1'b1);
    m_acc.delete();
    model_conv(w);
    checks++;
    if (n_valid !== int'(e_v) || (e_v && d_valid !== e_d)) begin
      failures++;
      $display("FAIL ovr_data got=%0d/%h exp=%0d/%h",
               n_valid, d_valid, e_v, e_d);
    end
    checks++;
    if (n_conv !== CW || sample_cnt !== m_cnt) begin
      failures++;
      $display("FAIL ovr_single got=%0d/%0d exp=%0d/%0d",
               n_conv, sample_cnt, CW, m_cnt);
    end
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_set got=%b exp=1", overrun);
    end
    pulse_clr();
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clr got=%b exp=0", overrun);
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] w;
    busy_stuck = 1'b1;
    conv(16'h1234, BT + 200, 1, 0, 1'b0);
    checks++;
    if (timeout_err !== 1'b1 || t_to < BT - 10 || t_to > BT + 10) begin
      failures++;
      $display("FAIL to_set got=%b@%0d exp=1@~%0d", timeout_err, t_to, BT);
    end
    checks++;
    if (n_valid !== 0 || n_cs !== 0 || sample_cnt !== m_cnt) begin
      failures++;
      $display("FAIL to_novalid got=%0d/%0d/%0d exp=0/0/%0d",
               n_valid, n_cs, sample_cnt, m_cnt);
    end
    busy_stuck = 1'b0;
    repeat (5) @(negedge clk);
    pulse_clr();
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL to_clr got=%b exp=0", timeout_err);
    end
    w = DW'($urandom);
    conv(w, 200, 1, 0, 1'b0);
    model_conv(w);
    checks++;
    if (n_valid !== int'(e_v) || (e_v && d_valid !== e_d)) begin
      failures++;
      $display("FAIL to_recover got=%0d/%h exp=%0d/%h",
               n_valid, d_valid, e_v, e_d);
    end
  endtask

  task automatic test_enable();
    logic [DW-1:0] w;
    en = 1'b0;
    conv(16'hFFFF, 60, 1, 0, 1'b0);
    checks++;
    if (n_conv !== 0 || n_valid !== 0 || overrun !== 1'b0 ||
        timeout_err !== 1'b0 || sample_cnt !== m_cnt) begin
      failures++;
      $display("FAIL en_off got=%0d/%0d/%b/%b exp=0/0/0/0",
               n_conv, n_valid, overrun, timeout_err);
    end
    en = 1'b1;
    w = DW'($urandom);
    conv(w, 200, 1, 0, 1'b0);
    model_conv(w);
    checks++;
    if (n_valid !== int'(e_v) || (e_v && d_valid !== e_d) ||
        sample_cnt !== m_cnt) begin
      failures++;
      $display("FAIL en_on got=%0d/%h/%0d exp=%0d/%h/%0d",
               n_valid, d_valid, sample_cnt, e_v, e_d, m_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w;
    int guard;
    @(negedge clk);
    adc_word = DW'($urandom);
    busy_dly = 8;
    ad_start = 1'b1;
    @(negedge clk);
    ad_start = 1'b0;
    guard = 0;
    while (rise_idx < 7 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 400) begin
      failures++;
      $display("FAIL rst_mid_reach got=%0d exp=7", rise_idx);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b0 || sample_data !== '0 ||
        sample_cnt !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid got=%b/%b/%h/%0d exp=1/0/0/0",
               adc_cs_n, adc_sclk, sample_data, sample_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0;
    m_acc.delete();
    repeat (20) @(negedge clk);
    w = DW'($urandom);
    conv(w, 200, 1, 0, 1'b0);
    model_conv(w);
    checks++;
    if (n_valid !== int'(e_v) || (e_v && d_valid !== e_d) ||
        sample_cnt !== m_cnt) begin
      failures++;
      $display("FAIL rst_mid_next got=%0d/%h/%0d exp=%0d/%h/%0d",
               n_valid, d_valid, sample_cnt, e_v, e_d, m_cnt);
    end
  endtask

`ifdef AD_AVG4_EN
  task automatic test_avg4();
    int vals[4] = '{100, 200, 300, 401};
    int nv;
    test_reset();
    nv = 0;
    foreach (vals[k]) begin
      conv(DW'(vals[k]), 200, 1, 0, 1'b0);
      model_conv(DW'(vals[k]));
      nv += n_valid;
    end
    checks++;
    if (nv !== 1 || d_valid !== DW'(250) || e_d !== DW'(250)) begin
      failures++;
      $display("FAIL avg4 got=%0d/%0d exp=1/250", nv, d_valid);
    end
    checks++;
    if (sample_cnt !== 32'd4) begin
      failures++;
      $display("FAIL avg4_cnt got=%0d exp=4", sample_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_timeout();
    test_enable();
    test_reset_mid();
`ifdef AD_AVG4_EN
    test_avg4();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
